// File: rtl/game_flow_controller_if.sv
// Play-sequencer bus: key/collision/frame inputs toward the controller, pause/launch/respawn/status back.
// Slave side is the controller; master side is the surrounding key/collision logic or a bench.
interface game_flow_controller_if;
  logic       startOfFrame;
  logic       key5IsPressed;
  logic       keyPauseIsPressed;
  logic       collisionSmileyBorderBottom;
  logic       pause;
  logic       launch;
  logic       respawn;
  logic [3:0] lives;
  logic       gameOver;
  logic [2:0] state;

  modport master (
    output startOfFrame, key5IsPressed, keyPauseIsPressed, collisionSmileyBorderBottom,
    input  pause, launch, respawn, lives, gameOver, state
  );

  modport slave (
    input  startOfFrame, key5IsPressed, keyPauseIsPressed, collisionSmileyBorderBottom,
    output pause, launch, respawn, lives, gameOver, state
  );
endinterface

// File: rtl/game_flow_controller.sv
// Smiley play sequencer: pause gating, launch/respawn pulses, lives and frame-timed loss delay.
// All outputs registered, 1 clk input-to-output latency; no backpressure (inputs are levels/pulses).
module game_flow_controller #(
  parameter int LIVES             = 3,
  parameter int LOST_DELAY_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  resetN,
  game_flow_controller_if.slave bus
);

  typedef enum logic [2:0] {
    READY     = 3'd0,
    PLAY      = 3'd1,
    PAUSED    = 3'd2,
    LOST      = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0] LIVES_INIT = 4'(LIVES);
  localparam logic [7:0] DLY_LAST   = 8'(LOST_DELAY_FRAMES - 1);

  state_t     state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] cnt_q, cnt_d;
  logic       launch_q, launch_d;
  logic       respawn_q, respawn_d;
  logic       key5_q, keyp_q;
  logic       key5_rise, keyp_rise;

  assign key5_rise = bus.key5IsPressed & ~key5_q;
  assign keyp_rise = bus.keyPauseIsPressed & ~keyp_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= READY;
      lives_q   <= LIVES_INIT;
      cnt_q     <= 8'd0;
      launch_q  <= 1'b0;
      respawn_q <= 1'b0;
      // Edge registers start high so a key held through reset gives no edge.
      key5_q    <= 1'b1;
      keyp_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      launch_q  <= launch_d;
      respawn_q <= respawn_d;
      key5_q    <= bus.key5IsPressed;
      keyp_q    <= bus.keyPauseIsPressed;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    launch_d  = 1'b0;
    respawn_d = 1'b0;
    unique case (state_q)
      READY: begin
        if (key5_rise) begin
          state_d  = PLAY;
          launch_d = 1'b1;
        end
      end
      PLAY: begin
        // Collision outranks a simultaneous pause press.
        if (bus.collisionSmileyBorderBottom) begin
          state_d = LOST;
          cnt_d   = 8'd0;
          lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
        end else if (keyp_rise) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (keyp_rise) state_d = PLAY;
      end
      LOST: begin
        if (bus.startOfFrame) begin
          if (cnt_q == DLY_LAST) begin
            if (lives_q != 4'd0) begin
              state_d   = READY;
              respawn_d = 1'b1;
            end else begin
              state_d = GAME_OVER;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      GAME_OVER: begin
        if (key5_rise) begin
          state_d   = READY;
          lives_d   = LIVES_INIT;
          respawn_d = 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

  assign bus.pause    = (state_q != PLAY);
  assign bus.launch   = launch_q;
  assign bus.respawn  = respawn_q;
  assign bus.lives    = lives_q;
  assign bus.gameOver = (state_q == GAME_OVER);
  assign bus.state    = state_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with LIVES=3, LOST_DELAY_FRAMES=4.
module tb_game_flow_controller;
  logic clk;
  logic resetN;
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam int S_READY = 0, S_PLAY = 1, S_PAUSED = 2, S_LOST = 3, S_OVER = 4;

  game_flow_controller_if gf ();

  game_flow_controller #(.LIVES(3), .LOST_DELAY_FRAMES(4)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (gf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int lv, input int pz,
                         input int ln, input int rs, input int go);
    chk({tag, ".state"},    int'(gf.state),    st);
    chk({tag, ".lives"},    int'(gf.lives),    lv);
    chk({tag, ".pause"},    int'(gf.pause),    pz);
    chk({tag, ".launch"},   int'(gf.launch),   ln);
    chk({tag, ".respawn"},  int'(gf.respawn),  rs);
    chk({tag, ".gameOver"}, int'(gf.gameOver), go);
  endtask

  task automatic frame();
    gf.startOfFrame = 1'b1;
    step();
    gf.startOfFrame = 1'b0;
    step();
  endtask

  task automatic press_key5();
    gf.key5IsPressed = 1'b1;
    step();
    gf.key5IsPressed = 1'b0;
  endtask

  // Three frames keep LOST; the fourth frame's edge exits.
  task automatic lost_delay(input string tag, input int lv_after, input bit to_over);
    frame();
    frame();
    frame();
    chk({tag, ".still_lost"}, int'(gf.state), S_LOST);
    gf.startOfFrame = 1'b1;
    step();
    gf.startOfFrame = 1'b0;
    if (to_over) chk_all({tag, ".exit"}, S_OVER, lv_after, 1, 0, 0, 1);
    else         chk_all({tag, ".exit"}, S_READY, lv_after, 1, 0, 1, 0);
    step();
    chk({tag, ".respawn_drop"}, int'(gf.respawn), 0);
  endtask

  initial begin
    resetN                         = 1'b0;
    gf.startOfFrame                = 1'b0;
    gf.key5IsPressed               = 1'b0;
    gf.keyPauseIsPressed           = 1'b0;
    gf.collisionSmileyBorderBottom = 1'b0;
    step();
    step();
    chk_all("reset", S_READY, 3, 1, 0, 0, 0);
    resetN = 1'b1;

    // READY ignores pause and collision
    gf.keyPauseIsPressed           = 1'b1;
    gf.collisionSmileyBorderBottom = 1'b1;
    step();
    chk_all("ready_ignore", S_READY, 3, 1, 0, 0, 0);
    gf.keyPauseIsPressed           = 1'b0;
    gf.collisionSmileyBorderBottom = 1'b0;
    step();

    // 1: key5 held 10 cycles -> single launch
    gf.key5IsPressed = 1'b1;
    step();
    chk_all("launch", S_PLAY, 3, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("held_no_relaunch", int'(gf.launch), 0);
    end
    chk("held_state", int'(gf.state), S_PLAY);
    gf.key5IsPressed = 1'b0;
    step();

    // 2: pause toggles
    gf.keyPauseIsPressed = 1'b1;
    step();
    chk_all("pause_on", S_PAUSED, 3, 1, 0, 0, 0);
    gf.keyPauseIsPressed = 1'b0;
    step();
    gf.keyPauseIsPressed = 1'b1;
    step();
    chk_all("pause_off", S_PLAY, 3, 0, 0, 0, 0);
    gf.keyPauseIsPressed = 1'b0;
    step();

    // 6a: collision and key5 while PAUSED are ignored
    gf.keyPauseIsPressed = 1'b1;
    step();
    gf.keyPauseIsPressed = 1'b0;
    gf.collisionSmileyBorderBottom = 1'b1;
    gf.key5IsPressed = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk_all("paused_coll", S_PAUSED, 3, 1, 0, 0, 0);
    gf.collisionSmileyBorderBottom = 1'b0;
    gf.key5IsPressed = 1'b0;
    step();
    gf.keyPauseIsPressed = 1'b1;
    step();
    chk("resume", int'(gf.state), S_PLAY);
    gf.keyPauseIsPressed = 1'b0;
    step();

    // 3: collision beats pause; entry-edge frame not counted; 6b: held collision in LOST
    gf.collisionSmileyBorderBottom = 1'b1;
    gf.keyPauseIsPressed           = 1'b1;
    gf.startOfFrame                = 1'b1;
    step();
    chk_all("loss1", S_LOST, 2, 1, 0, 0, 0);
    gf.keyPauseIsPressed = 1'b0;
    gf.startOfFrame      = 1'b0;
    step();
    lost_delay("delay1", 2, 1'b0);
    gf.collisionSmileyBorderBottom = 1'b0;
    step();

    // 4: two more losses -> GAME_OVER, then restart
    press_key5();
    chk("launch2", int'(gf.launch), 1);
    gf.collisionSmileyBorderBottom = 1'b1;
    step();
    gf.collisionSmileyBorderBottom = 1'b0;
    chk_all("loss2", S_LOST, 1, 1, 0, 0, 0);
    lost_delay("delay2", 1, 1'b0);
    press_key5();
    gf.collisionSmileyBorderBottom = 1'b1;
    step();
    gf.collisionSmileyBorderBottom = 1'b0;
    chk_all("loss3", S_LOST, 0, 1, 0, 0, 0);
    lost_delay("delay3", 0, 1'b1);
    gf.keyPauseIsPressed = 1'b1;
    step();
    gf.keyPauseIsPressed = 1'b0;
    chk_all("over_hold", S_OVER, 0, 1, 0, 0, 1);
    press_key5();
    chk_all("restart", S_READY, 3, 1, 0, 1, 0);
    step();
    chk("restart_drop", int'(gf.respawn), 0);

    // 5: reset mid-LOST with key5 held
    press_key5();
    gf.collisionSmileyBorderBottom = 1'b1;
    step();
    gf.collisionSmileyBorderBottom = 1'b0;
    chk("loss4_lives", int'(gf.lives), 2);
    frame();
    frame();
    gf.key5IsPressed = 1'b1;
    resetN = 1'b0;
    step();
    chk_all("mid_reset", S_READY, 3, 1, 0, 0, 0);
    resetN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_thru_reset", int'(gf.launch), 0);
    end
    chk("held_thru_reset_state", int'(gf.state), S_READY);
    gf.key5IsPressed = 1'b0;
    step();
    press_key5();
    chk_all("relaunch", S_PLAY, 3, 0, 1, 0, 0);
    step();
    chk("relaunch_drop", int'(gf.launch), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
